// File: rtl/des_round_key_gen.sv
// DES key schedule: emits the 16 round keys in encryption or decryption order,
// one per key_valid/key_ready handshake, with round_key computed combinationally from C/D.
module des_round_key_gen (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        key_ready,
    output logic [47:0] round_key,
    output logic [3:0]  round_num,
    output logic        key_valid,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Tables hold FIPS 1-based bit positions; bit 1 is the MSB of each vector.
    localparam logic [6:0] PC1_TAB [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };
    localparam logic [6:0] PC2_TAB [48] = '{
        7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
        7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
        7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
        7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  src, dst;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src    = 6'(7'd64 - PC1_TAB[i]);
            dst    = 6'(55 - i);
            r[dst] = k[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  src, dst;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            src    = 6'(7'd56 - PC2_TAB[i]);
            dst    = 6'(47 - i);
            r[dst] = cd[src];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  rnd_q, rnd_d;
    logic        dec_q, dec_d;
    logic [55:0] cd_ld;
    logic [3:0]  nxt;
    logic        two;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        dec_d   = dec_q;
        cd_ld   = pc1(key_in);
        nxt     = rnd_q + 4'd1;
        // Encrypt and decrypt share one-step positions 1, 8 and 15; all others step by 2.
        two     = !(nxt == 4'd1 || nxt == 4'd8 || nxt == 4'd15);
        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d     = decrypt ? cd_ld[55:28] : rotl(cd_ld[55:28], 1'b0);
                    d_d     = decrypt ? cd_ld[27:0]  : rotl(cd_ld[27:0], 1'b0);
                    dec_d   = decrypt;
                    rnd_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (key_ready) begin
                    if (rnd_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        rnd_d = nxt;
                        c_d   = dec_q ? rotr(c_q, two) : rotl(c_q, two);
                        d_d   = dec_q ? rotr(d_q, two) : rotl(d_q, two);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign round_key = pc2({c_q, d_q});
    assign round_num = rnd_q;
    assign key_valid = (state_q == ROUND);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_des_round_key_gen.sv
// Directed bench for des_round_key_gen against the published round keys of 133457799BBCDFF1.
module tb_des_round_key_gen;
    logic        clk, n_rst, start, decrypt, key_ready;
    logic [63:0] key_in;
    logic [47:0] round_key;
    logic [3:0]  round_num;
    logic        key_valid, busy, done;

    int tests = 0;
    int fails = 0;

    des_round_key_gen dut (
        .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt), .key_in(key_in),
        .key_ready(key_ready), .round_key(round_key), .round_num(round_num),
        .key_valid(key_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [47:0] K [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        bp;
        logic        inj;
        logic [47:0] exp_first;
        logic [47:0] exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller is at a negedge; drives start now and walks the whole sequence.
    task automatic run_seq(input logic [63:0] key, input logic dec, input logic bp,
                           input logic inj, input logic [47:0] e0, input logic [47:0] e15);
        int          pos, edges, guard;
        logic        rdy;
        logic [47:0] exp, last;
        start = 1'b1; key_in = key; decrypt = dec; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; edges = 1; pos = 0; guard = 0; last = '0;
        while (pos < 16 && guard < 200) begin
            exp = dec ? K[15-pos] : K[pos];
            chk("key_valid", {63'd0, key_valid}, 64'd1);
            chk("round_num", {60'd0, round_num}, 64'(pos));
            chk("round_key", {16'd0, round_key}, {16'd0, exp});
            if (pos == 0)  chk("first_key", {16'd0, round_key}, {16'd0, e0});
            if (pos == 15) chk("last_key", {16'd0, round_key}, {16'd0, e15});
            last      = exp;
            rdy       = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            key_ready = rdy;
            key_in    = {$urandom, $urandom};
            decrypt   = 1'($urandom_range(0, 1));
            start     = inj && (pos == 7);
            @(negedge clk);
            edges++; guard++;
            if (rdy) pos++;
        end
        chk("seq_complete", 64'(pos), 64'd16);
        key_ready = 1'b0;
        start     = inj;
        key_in    = 64'h0F1E2D3C4B5A6978;
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_valid", {63'd0, key_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        edges++;
        start = 1'b0;
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_valid", {63'd0, key_valid}, 64'd0);
        chk("idle_key_held", {16'd0, round_key}, {16'd0, last});
        if (!bp) chk("cycles", 64'(edges), 64'd18);
        if (inj) begin
            @(negedge clk);
            chk("no_queued_start", {63'd0, busy}, 64'd0);
            chk("no_second_done", {63'd0, done}, 64'd0);
        end
    endtask

    vec_t vecs [6];

    initial begin
        int g;
        vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[2] = '{64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[3] = '{64'h123456789ABCDEF0, 1'b0, 1'b0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[4] = '{64'h133557799BBDDFF1, 1'b0, 1'b0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[5] = '{64'h133557799BBDDFF1, 1'b1, 1'b1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};

        n_rst = 1'b0; start = 1'b0; decrypt = 1'b0; key_ready = 1'b0; key_in = '0;
        #1;
        chk("rst_key", {16'd0, round_key}, 64'd0);
        chk("rst_rnum", {60'd0, round_num}, 64'd0);
        chk("rst_valid", {63'd0, key_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_seq(vecs[i].key, vecs[i].dec, vecs[i].bp, vecs[i].inj, vecs[i].exp_first, vecs[i].exp_last);

        // Asynchronous reset in the middle of a sequence.
        @(negedge clk);
        start = 1'b1; key_in = 64'h133457799BBCDFF1; decrypt = 1'b0;
        @(negedge clk);
        start = 1'b0; key_ready = 1'b1; g = 0;
        while (round_num != 4'd9 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("mid_rnum", {60'd0, round_num}, 64'd9);
        chk("mid_key", {16'd0, round_key}, {16'd0, K[9]});
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_key", {16'd0, round_key}, 64'd0);
        chk("arst_rnum", {60'd0, round_num}, 64'd0);
        chk("arst_valid", {63'd0, key_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        key_ready = 1'b0;
        @(negedge clk);
        chk("arst_hold_done", {63'd0, done}, 64'd0);
        n_rst = 1'b1;
        run_seq(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/des_round_key_gen.md
DES_ROUND_KEY_GEN -- requirements
Module: des_round_key_gen

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by FIPS 46-3.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 n_rst  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a new 16-round key sequence; sampled only in IDLE.
REQ-005 decrypt  input  1  0 = encryption order K1..K16, 1 = decryption order K16..K1; sampled with start.
REQ-006 key_in  input  64  DES key, FIPS bit 1 = key_in[63]; parity bits ignored; sampled with start.
REQ-007 key_ready  input  1  consumer accepts the current round_key this cycle.
REQ-008 round_key  output  48  current 48-bit round key, FIPS bit 1 = round_key[47].
REQ-009 round_num  output  4  index of the current key position in the sequence, 0..15.
REQ-010 key_valid  output  1  round_key/round_num are valid.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse after the 16th key is accepted.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ROUND and DONE.
REQ-014 IDLE with start=1 at edge N SHALL:
- load C/D from PC-1(key_in)
- pre-rotate by 1 left for encryption, by 0 for decryption
- latch decrypt
- set round_num=0
- enter ROUND, giving key_valid=1 in cycle N+1.
REQ-015 In ROUND, round_key SHALL equal PC-2 of the registered C/D with no added latency, and key_valid SHALL be 1.
REQ-016 A handshake SHALL occur on an edge where key_valid=1 and key_ready=1.
- Without a handshake, C/D, round_num and round_key SHALL hold unchanged.
REQ-017 On each handshake with round_num<15, round_num SHALL increment by 1 and C and D (28 bits each) SHALL rotate by the shift amount of the next position.
- Encryption: left rotate by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for round_num 0..15.
- Decryption: right rotate by 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotation wraps bit 28 to bit 1 within each half.
REQ-018 A handshake at round_num=15 SHALL move to DONE.
- key_valid drops in the following cycle.
- C/D SHALL NOT rotate further.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 start asserted while busy=1, including in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-021 Changes on key_in or decrypt while busy=1 SHALL NOT affect the sequence in progress.
REQ-022 In IDLE and DONE, key_valid SHALL be 0. round_key and round_num are don't-care but SHALL be deterministic, held from their last value.
REQ-023 Minimum cycles from start to done SHALL be 18: start edge, 16 handshake cycles, then the DONE cycle.

Reset
REQ-024 n_rst=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE
- C/D=0, round_num=0, round_key=PC-2(0)=0
- key_valid=0, busy=0, done=0.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse.
- After release, the block SHALL accept a new start on the first edge.
REQ-026 The first rising edge after n_rst rises SHALL be treated as a normal IDLE cycle.

Verification
REQ-027 Encryption, key_in=64'h133457799BBCDFF1, key_ready held 1, decrypt=0 -> round 0 key 48'h1B02EFFC7072, round 15 key 48'hCB3D8B0E17F5, done one cycle later, 18 cycles total.
REQ-028 Same key with decrypt=1 -> round 0 key 48'hCB3D8B0E17F5, round 15 key 48'h1B02EFFC7072; all 16 keys equal the encryption list reversed.
REQ-029 Backpressure, key_ready toggling pseudo-randomly -> round_key and round_num stable while key_ready=0, no key skipped or duplicated, same 16-key list as REQ-027.
REQ-030 start pulsed at round_num=7 and in DONE with a different key_in -> sequence unchanged, a single done, block returns to IDLE.
REQ-031 n_rst pulled low at round_num=9 between clock edges -> outputs reach reset values before the next edge, no done; a fresh start then reproduces REQ-027.
REQ-032 Parity independence, key_in=64'h123456789ABCDEF0 vs 64'h133557799BBDDFF1 (LSBs of each byte differ) -> identical 16-key sequences.
